// File: rtl/uart_msg_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_msg_assembler
// Function : Packs consecutive UART words into one wide message, first word
//            in the LSBs, with idle timeout and framing-error abort.
// Revision : 1.0
// ============================================================================
module uart_msg_assembler #(
    parameter int DATA_WIDTH   = 8,
    parameter int MSG_WIDTH    = 64,
    parameter int TIMEOUT_CLKS = 216000
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    input  logic                  frame_err,
    output logic [MSG_WIDTH-1:0]  msg_out,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic                  word_dropped,
    output logic                  msg_aborted
);

    localparam int c_WORDS  = MSG_WIDTH / DATA_WIDTH;
    localparam int c_CNT_W  = $clog2(c_WORDS) + 1;
    localparam int c_IDLE_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL     = c_CNT_W'(c_WORDS);
    localparam logic [c_IDLE_W-1:0] c_TIMEOUT_LAST = c_IDLE_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t                r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [c_IDLE_W-1:0]   r_idle,    w_idle_nxt;
    logic [MSG_WIDTH-1:0]  r_msg,     w_msg_nxt;
    logic                  r_dropped, w_dropped_nxt;
    logic                  r_aborted, w_aborted_nxt;
    logic                  w_wr;
    logic [c_CNT_W-1:0]    w_slot;
    logic [c_CNT_W-1:0]    w_cnt_inc;

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_msg     <= '0;
            r_dropped <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idle    <= w_idle_nxt;
            r_msg     <= w_msg_nxt;
            r_dropped <= w_dropped_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idle_nxt    = '0;
        w_dropped_nxt = 1'b0;
        w_aborted_nxt = 1'b0;
        w_wr          = 1'b0;
        w_slot        = '0;

        case (r_state)
            S_IDLE: begin
                if (word_valid) begin
                    if (frame_err) begin
                        w_dropped_nxt = 1'b1;
                    end else begin
                        w_wr        = 1'b1;
                        w_cnt_nxt   = c_CNT_W'(1);
                        w_state_nxt = (c_WORDS == 1) ? S_HOLD : S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                w_idle_nxt = r_idle + c_IDLE_W'(1);
                // A word landing on the timeout cycle still extends the message.
                if (frame_err) begin
                    w_aborted_nxt = 1'b1;
                    w_dropped_nxt = word_valid;
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_idle_nxt    = '0;
                end else if (word_valid) begin
                    w_wr       = 1'b1;
                    w_slot     = r_cnt;
                    w_cnt_nxt  = w_cnt_inc;
                    w_idle_nxt = '0;
                    if (w_cnt_inc == c_CNT_FULL) begin
                        w_state_nxt = S_HOLD;
                    end
                end else if (r_idle == c_TIMEOUT_LAST) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_idle_nxt    = '0;
                end
            end

            S_HOLD: begin
                if (msg_ready) begin
                    if (word_valid) begin
                        w_wr        = 1'b1;
                        w_cnt_nxt   = c_CNT_W'(1);
                        w_state_nxt = (c_WORDS == 1) ? S_HOLD : S_COLLECT;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (word_valid) begin
                    w_dropped_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_msg_nxt = r_msg;
        for (int k = 0; k < c_WORDS; k++) begin
            if (w_wr && (w_slot == c_CNT_W'(k))) begin
                w_msg_nxt[k*DATA_WIDTH +: DATA_WIDTH] = word_in;
            end
        end
    end

    assign msg_out      = r_msg;
    assign msg_valid    = (r_state == S_HOLD);
    assign word_dropped = r_dropped;
    assign msg_aborted  = r_aborted;

endmodule
`default_nettype wire
